// File: rtl/ex_alu_stage.sv
// ex_alu_stage: execute-stage ALU with branch resolution and EX/MEM pipeline register
module ex_alu_stage #(
    parameter int WIDTH = 32,
    parameter int RBITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] store_data_in,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] imm_ext,
    input  logic [RBITS-1:0] dest_in,
    input  logic             reg_write_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             overflow,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] store_data,
    output logic [RBITS-1:0] dest_out,
    output logic             reg_write_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic             illegal_op
);
    logic [WIDTH-1:0] sum, diff, res, target;
    logic             ovf, taken, legal;
    assign sum    = op_a + op_b;
    assign diff   = op_a - op_b;
    assign target = pc_plus4 + (imm_ext << 2);
    assign zero   = (alu_result == '0);
    always_comb begin
        res   = '0;
        ovf   = 1'b0;
        taken = 1'b0;
        legal = 1'b1;
        case (alu_ctrl)
            4'b0000: begin
                res = sum;
                ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'b0001: begin
                res = diff;
                ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'b0010: res = op_a & op_b;
            4'b0011: res = ~(op_a | op_b);
            4'b0100: res = op_a | op_b;
            4'b0101: res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'b0110: begin
                res   = diff;
                taken = (op_a == op_b);
            end
            4'b0111: begin
                res   = diff;
                taken = (op_a != op_b);
            end
            4'b1111: begin
                res   = op_a;
                taken = ~op_a[WIDTH-1];
            end
            default: legal = 1'b0;
        endcase
    end
    // an empty ID/EX slot loads exactly like a flush
    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && !in_valid)) begin
            out_valid     <= 1'b0;
            alu_result    <= '0;
            overflow      <= 1'b0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
            store_data    <= '0;
            dest_out      <= '0;
            reg_write_out <= 1'b0;
            mem_read_out  <= 1'b0;
            mem_write_out <= 1'b0;
            illegal_op    <= 1'b0;
        end else if (!stall) begin
            out_valid     <= 1'b1;
            alu_result    <= res;
            overflow      <= ovf;
            branch_taken  <= taken;
            branch_target <= target;
            store_data    <= store_data_in;
            dest_out      <= dest_in;
            reg_write_out <= reg_write_in && legal;
            mem_read_out  <= mem_read_in && legal;
            mem_write_out <= mem_write_in && legal;
            illegal_op    <= !legal;
        end
    end
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed and randomized checks of ex_alu_stage against an arithmetic reference model
module tb_ex_alu_stage;
    logic        clk = 0, reset, in_valid, stall, flush;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a, op_b, store_data_in, pc_plus4, imm_ext;
    logic [4:0]  dest_in;
    logic        reg_write_in, mem_read_in, mem_write_in;
    logic        out_valid, zero, overflow, branch_taken, reg_write_out, mem_read_out, mem_write_out, illegal_op;
    logic [31:0] alu_result, branch_target, store_data;
    logic [4:0]  dest_out;
    int          n_vec = 0, n_bad = 0;

    typedef struct {
        bit          valid, ovf, taken, rw, mr, mw, ill;
        bit [31:0]   res, target, sd;
        bit [4:0]    dest;
    } exp_t;
    exp_t e;

    ex_alu_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .store_data_in(store_data_in),
        .pc_plus4(pc_plus4), .imm_ext(imm_ext), .dest_in(dest_in),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .out_valid(out_valid), .alu_result(alu_result), .zero(zero), .overflow(overflow),
        .branch_taken(branch_taken), .branch_target(branch_target), .store_data(store_data),
        .dest_out(dest_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference: true signed results via 64-bit arithmetic, overflow = out of 32-bit range
    function automatic exp_t model(input bit [3:0] c, input bit [31:0] a, b, sd, pc, imm,
                                   input bit [4:0] d, input bit rw, mr, mw);
        exp_t   m;
        longint sa = longint'($signed(a)), sb = longint'($signed(b)), t;
        bit     legal = 1;
        m = '{default: 0};
        case (c)
            4'd0: begin t = sa + sb; m.res = a + b; m.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            4'd1: begin t = sa - sb; m.res = a - b; m.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            4'd2: m.res = a & b;
            4'd3: m.res = ~(a | b);
            4'd4: m.res = a | b;
            4'd5: m.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd6: begin m.res = a - b; m.taken = (a == b); end
            4'd7: begin m.res = a - b; m.taken = (a != b); end
            4'd15: begin m.res = a; m.taken = (sa >= 0); end
            default: legal = 0;
        endcase
        m.valid  = 1;
        m.ill    = !legal;
        m.target = pc + imm * 32'd4;
        m.sd     = sd;
        m.dest   = d;
        m.rw     = rw && legal;
        m.mr     = mr && legal;
        m.mw     = mw && legal;
        return m;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(e.valid));
        chk({tag, ".result"}, alu_result, e.res);
        chk({tag, ".zero"}, 32'(zero), 32'(e.res == 0));
        chk({tag, ".ovf"}, 32'(overflow), 32'(e.ovf));
        chk({tag, ".taken"}, 32'(branch_taken), 32'(e.taken));
        chk({tag, ".target"}, branch_target, e.target);
        chk({tag, ".sd"}, store_data, e.sd);
        chk({tag, ".dest"}, 32'(dest_out), 32'(e.dest));
        chk({tag, ".ctl"}, {29'd0, reg_write_out, mem_read_out, mem_write_out}, {29'd0, e.rw, e.mr, e.mw});
        chk({tag, ".ill"}, 32'(illegal_op), 32'(e.ill));
    endtask

    task automatic apply(input string tag, input bit rst, v, st, fl, input bit [3:0] c,
                         input bit [31:0] a, b, sd, pc, imm, input bit [4:0] d, input bit rw, mr, mw);
        reset = rst; in_valid = v; stall = st; flush = fl; alu_ctrl = c; op_a = a; op_b = b;
        store_data_in = sd; pc_plus4 = pc; imm_ext = imm; dest_in = d;
        reg_write_in = rw; mem_read_in = mr; mem_write_in = mw;
        @(posedge clk);
        #1;
        if (rst || fl || (!st && !v)) e = '{default: 0};
        else if (!st) e = model(c, a, b, sd, pc, imm, d, rw, mr, mw);
        check_all(tag);
    endtask

    task automatic op(input string tag, input bit [3:0] c, input bit [31:0] a, b, pc, imm);
        apply(tag, 0, 1, 0, 0, c, a, b, 32'h1234, pc, imm, 5'd7, 1, 0, 0);
    endtask

    initial begin
        bit [3:0] codes [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd15};
        apply("reset", 1, 1, 0, 0, 0, 5, 5, 1, 1, 1, 3, 1, 1, 1);
        op("add", 0, 7, 5, 0, 0);
        chk("add12", alu_result, 32'd12);
        op("sub_ovf", 1, 32'h80000000, 1, 0, 0);
        chk("sub_ovf_flag", 32'(overflow), 1);
        op("add_ovf", 0, 32'h7FFFFFFF, 1, 0, 0);
        chk("add_ovf_res", alu_result, 32'h80000000);
        op("slt1", 5, 32'hFFFFFFFF, 1, 0, 0);
        op("slt2", 5, 32'h80000000, 32'h7FFFFFFF, 0, 0);
        op("slt3", 5, 32'h7FFFFFFF, 32'h80000000, 0, 0);
        chk("slt_swapped", alu_result, 0);
        op("beq", 6, 9, 9, 32'h100, 32'hFFFFFFFE);
        chk("beq_target", branch_target, 32'hF8);
        chk("beq_taken", 32'(branch_taken), 1);
        op("bgez", 15, 32'h80000000, 0, 0, 0);
        op("bneq", 7, 3, 4, 0, 0);
        op("load_add", 0, 100, 23, 4, 1);
        for (int i = 0; i < 3; i++)
            apply("stall", 0, 1, 1, 0, 4'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 1, 1, 1);
        chk("stall_hold", alu_result, 32'd123);
        apply("stall_flush", 0, 1, 1, 1, 0, 1, 2, 3, 4, 5, 6, 1, 1, 1);
        op("load_again", 0, 1, 1, 0, 0);
        apply("stall_pre_rst", 0, 1, 1, 0, 0, 9, 9, 9, 9, 9, 9, 1, 1, 1);
        apply("rst_in_stall", 1, 1, 1, 0, 0, 9, 9, 9, 9, 9, 9, 1, 1, 1);
        apply("illegal", 0, 1, 0, 0, 4'b1000, 5, 6, 7, 8, 9, 5'd12, 1, 0, 1);
        chk("illegal_flag", 32'(illegal_op), 1);
        apply("bubble", 0, 0, 0, 0, 0, 5, 6, 7, 8, 9, 5'd12, 1, 1, 1);
        for (int i = 0; i < 400; i++) begin
            bit [31:0] b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            bit [31:0] a = ($urandom_range(0, 3) == 0) ? b : $urandom;
            bit [3:0]  c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 8)];
            apply("rand", $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, c, a, b, $urandom, $urandom, $urandom, 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
